// File: rtl/dsptmg_pkg.sv
// Shared display constants for the 640x480 text-mode pipeline (timing generator,
// display memory and character generator all import this package).
package dsptmg_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;

  localparam int V_VISIBLE    = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  localparam int GLYPH_W   = 8;
  localparam int GLYPH_H   = 16;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;

  // Field widths of the text/glyph coordinates carved out of the counters
  localparam int CHR_COL_W = $clog2(GLYPH_W);
  localparam int CHR_ROW_W = $clog2(GLYPH_H);
  localparam int TXT_COL_W = $clog2(TEXT_COLS);
  localparam int TXT_ROW_W = $clog2(TEXT_ROWS);

  function automatic logic in_span(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/dsptmg.sv
// Display timing generator: pixel enable, raster counters, sync/blank decode
// and a slow blink phase derived from a frame counter.
module dsptmg
  import dsptmg_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_SS  = H_SYNC_START,
  parameter int H_SE  = H_SYNC_END,
  parameter int H_TOT = H_TOTAL,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_SS  = V_SYNC_START,
  parameter int V_SE  = V_SYNC_END,
  parameter int V_TOT = V_TOTAL
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 pixclk,
  output logic [TXT_ROW_W-1:0] txtrow,
  output logic [TXT_COL_W-1:0] txtcol,
  output logic [CHR_ROW_W-1:0] chrrow,
  output logic [CHR_COL_W-1:0] chrcol,
  output logic                 blank,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blink
);

  logic       div;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [4:0] frame;
  logic       h_last;
  logic       v_last;

  assign h_last = (hcnt == 10'(H_TOT - 1));
  assign v_last = (vcnt == 10'(V_TOT - 1));

  // Counters only move on pixel-enable edges; all three wrap together at end of frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= 1'b0;
      hcnt  <= 10'd0;
      vcnt  <= 10'd0;
      frame <= 5'd0;
    end else begin
      div <= ~div;
      if (div) begin
        if (h_last) begin
          hcnt <= 10'd0;
          if (v_last) begin
            vcnt  <= 10'd0;
            frame <= frame + 5'd1;
          end else begin
            vcnt <= vcnt + 10'd1;
          end
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  // Pure decode of registered state; the display memory adds its own pipeline stage
  always_comb begin
    pixclk = div;
    chrcol = hcnt[CHR_COL_W-1:0];
    txtcol = hcnt[CHR_COL_W +: TXT_COL_W];
    chrrow = vcnt[CHR_ROW_W-1:0];
    txtrow = vcnt[CHR_ROW_W +: TXT_ROW_W];
    blank  = (hcnt >= 10'(H_VIS)) || (vcnt >= 10'(V_VIS));
    hsync  = ~in_span(int'(hcnt), H_SS, H_SE);
    vsync  = ~in_span(int'(vcnt), V_SS, V_SE);
    blink  = frame[4];
  end

endmodule

// File: tb/tb_dsptmg.sv
// Directed bench for dsptmg: full-size instance for line/reset timing, shrunken
// instances so vertical timing and 32-frame blink fit in a short run.
module tb_dsptmg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       pixclk, blank, hsync, vsync, blink;
  logic [4:0] txtrow;
  logic [6:0] txtcol;
  logic [3:0] chrrow;
  logic [2:0] chrcol;

  logic       pixclk_v, blank_v, hsync_v, vsync_v, blink_v;
  logic [4:0] txtrow_v;
  logic [6:0] txtcol_v;
  logic [3:0] chrrow_v;
  logic [2:0] chrcol_v;

  logic       pixclk_b, blank_b, hsync_b, vsync_b, blink_b;
  logic [4:0] txtrow_b;
  logic [6:0] txtcol_b;
  logic [3:0] chrrow_b;
  logic [2:0] chrcol_b;

  dsptmg dut (
    .clk(clk), .rst(rst), .pixclk(pixclk), .txtrow(txtrow), .txtcol(txtcol),
    .chrrow(chrrow), .chrcol(chrcol), .blank(blank), .hsync(hsync),
    .vsync(vsync), .blink(blink)
  );

  // Real vertical timing, 8-pixel lines: one frame is 8*525*2 = 8400 clk
  dsptmg #(.H_VIS(4), .H_SS(5), .H_SE(6), .H_TOT(8)) dut_v (
    .clk(clk), .rst(rst), .pixclk(pixclk_v), .txtrow(txtrow_v), .txtcol(txtcol_v),
    .chrrow(chrrow_v), .chrcol(chrcol_v), .blank(blank_v), .hsync(hsync_v),
    .vsync(vsync_v), .blink(blink_v)
  );

  // 8x8 raster: one frame is 128 clk, so 32 frames take 4096 clk
  dsptmg #(.H_VIS(4), .H_SS(5), .H_SE(6), .H_TOT(8),
           .V_VIS(4), .V_SS(5), .V_SE(6), .V_TOT(8)) dut_b (
    .clk(clk), .rst(rst), .pixclk(pixclk_b), .txtrow(txtrow_b), .txtcol(txtcol_b),
    .chrrow(chrrow_b), .chrcol(chrcol_b), .blank(blank_b), .hsync(hsync_b),
    .vsync(vsync_b), .blink(blink_b)
  );

  wire [9:0]  h    = {txtcol, chrcol};
  wire [8:0]  v    = {txtrow, chrrow};
  wire [9:0]  h_v  = {txtcol_v, chrcol_v};
  wire [8:0]  v_v  = {txtrow_v, chrrow_v};
  wire [9:0]  h_b  = {txtcol_b, chrcol_b};
  wire [8:0]  v_b  = {txtrow_b, chrrow_b};
  wire [23:0] outs   = {pixclk, txtrow, txtcol, chrrow, chrcol, blank, hsync, vsync, blink};
  wire [23:0] outs_v = {pixclk_v, txtrow_v, txtcol_v, chrrow_v, chrcol_v, blank_v, hsync_v, vsync_v, blink_v};
  wire [23:0] outs_b = {pixclk_b, txtrow_b, txtcol_b, chrrow_b, chrcol_b, blank_b, hsync_b, vsync_b, blink_b};

  // Reset pattern: everything zero except the two active-low syncs
  localparam logic [23:0] RESET_OUTS = 24'h000006;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_outs"},   32'(outs),   32'(RESET_OUTS));
    checkOutput({tag, "_outs_v"}, 32'(outs_v), 32'(RESET_OUTS));
    checkOutput({tag, "_outs_b"}, 32'(outs_b), 32'(RESET_OUTS));
  endtask

  // Assumes rst was just released between edges
  task automatic checkStartup(input string tag);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("%s_pix_e%0d", tag, k), 32'(pixclk), k % 2);
      checkOutput($sformatf("%s_hcnt_e%0d", tag, k), 32'(h), k / 2);
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs_cnt, hs_first, blank_rise, col637, chr637, blank637;
    int prev_blank, found300;
    int frame_len, vs_ticks, vs_first, row479_seen, row480_blank;
    int tr479, cr479, bl479, prev_start, cur_start;

    rst = 1'b1;
    applyStimulus(3);
    checkReset("por");
    @(negedge clk);
    rst = 1'b0;
    checkStartup("rel1");

    // One full line: hcnt now 4, one sample per pixel after each even edge
    hs_cnt = 0; hs_first = -1; blank_rise = -1; prev_blank = 0;
    col637 = -1; chr637 = -1; blank637 = -1;
    for (int i = 5; i <= 800; i++) begin
      applyStimulus(2);
      if (!hsync) begin
        if (hs_cnt == 0) hs_first = int'(h);
        hs_cnt++;
      end
      if (blank && prev_blank == 0) blank_rise = int'(h);
      prev_blank = int'(blank);
      if (h == 10'd637) begin
        col637 = int'(txtcol); chr637 = int'(chrcol); blank637 = int'(blank);
      end
    end
    checkOutput("hsync_low_pixels", 32'(hs_cnt), 96);
    checkOutput("hsync_first_hcnt", 32'(hs_first), 656);
    checkOutput("blank_rise_hcnt", 32'(blank_rise), 640);
    checkOutput("txtcol_at_637", 32'(col637), 79);
    checkOutput("chrcol_at_637", 32'(chr637), 5);
    checkOutput("blank_at_637", 32'(blank637), 0);
    checkOutput("hcnt_after_800", 32'(h), 0);
    checkOutput("vcnt_after_line", 32'(v), 1);
    checkOutput("blank_line1_start", 32'(blank), 0);

    // Asynchronous reset in the middle of a line
    found300 = 0;
    for (int i = 0; i < 700 && found300 == 0; i++) begin
      applyStimulus(1);
      if (h == 10'd300) found300 = 1;
    end
    checkOutput("reach_hcnt300", 32'(found300), 1);
    #4;
    rst = 1'b1;
    #1;
    checkReset("mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkStartup("rel2");

    // Vertical timing on dut_v and blink on dut_b, both counted from the release
    frame_len = 0; vs_ticks = 0; vs_first = -1; row479_seen = 0;
    row480_blank = -1; tr479 = -1; cr479 = -1; bl479 = -1; prev_start = 0;
    for (int e = 9; e <= 9000 && frame_len == 0; e++) begin
      applyStimulus(1);
      if (!vsync_v) begin
        if (vs_ticks == 0) vs_first = int'(v_v);
        vs_ticks++;
      end
      if (v_v == 9'd479 && h_v == 10'd3 && row479_seen == 0) begin
        row479_seen = 1;
        tr479 = int'(txtrow_v); cr479 = int'(chrrow_v); bl479 = int'(blank_v);
      end
      if (v_v == 9'd480 && h_v == 10'd0 && row480_blank < 0) row480_blank = int'(blank_v);
      if (e % 128 == 0 && e <= 4096) begin
        checkOutput($sformatf("blink_frame%0d", e / 128), 32'(blink_b),
                    (e / 128 >= 16 && e / 128 < 32) ? 1 : 0);
      end
      if (e == 4096) checkOutput("frame32_origin", 32'({h_b, v_b}), 0);
      cur_start = (h_v == 10'd0 && v_v == 9'd0 && !blank_v) ? 1 : 0;
      if (cur_start == 1 && prev_start == 0) frame_len = e;
      prev_start = cur_start;
    end
    checkOutput("frame_len_clk", 32'(frame_len), 8400);
    checkOutput("vsync_low_pixels", 32'(vs_ticks / 2), 16);
    checkOutput("vsync_first_vcnt", 32'(vs_first), 490);
    checkOutput("txtrow_at_479", 32'(tr479), 29);
    checkOutput("chrrow_at_479", 32'(cr479), 15);
    checkOutput("blank_at_479", 32'(bl479), 0);
    checkOutput("blank_at_480", 32'(row480_blank), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
